// File: rtl/gaussian_frame_ctrl.sv
// Purpose: frame sequencer for the Gaussian wrapper; streams IMG_W*IMG_H pixels in, flushes with zeros, forwards exactly IMG_W*IMG_H filtered pixels out.
// Latency: zero added latency on both paths (input and output are combinational pass-throughs gated by state).
// Backpressure: input stalls on src_empty / gs_ready; output stalls the wrapper via gs_rd_en_up when snk_full, except while priming outputs are discarded.
//
// Ports: clk/rst (async, active-low), start/busy/frame_done (frame control),
//        src_* (upstream FWFT FIFO), gs_* (Gaussian wrapper in/out), snk_* (sink FIFO).
// Optional: define GAUSS_CTRL_STALL_CNT_EN to add the stall_cycles[31:0] output.
module gaussian_frame_ctrl #(
  parameter int IMG_W = 800,
  parameter int IMG_H = 600,
  parameter int PRIME = 802,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  input  logic       src_empty,
  output logic       src_rd_en,
  input  logic [7:0] src_data,
  output logic       gs_valid,
  output logic [7:0] gs_din,
  input  logic       gs_ready,
  input  logic       gs_valid_out,
  input  logic [7:0] gs_dout,
  output logic       gs_rd_en_up,
  input  logic       snk_full,
  output logic       snk_wr_en,
  output logic [7:0] snk_data
`ifdef GAUSS_CTRL_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] TOTAL   = CNT_W'(IMG_W * IMG_H);
  localparam logic [CNT_W-1:0] LAST_IN = CNT_W'(IMG_W * IMG_H - 1);
  localparam logic [CNT_W-1:0] PRIME_C = CNT_W'(PRIME);
  localparam logic [CNT_W-1:0] LAST_FL = CNT_W'(PRIME - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, STREAM, FLUSH, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] in_cnt, out_cnt, disc_cnt, fl_cnt;
  logic             discarding, out_fire, out_write, frame_start;

  // The first PRIME wrapper outputs are line-buffer priming garbage.
  assign discarding  = (disc_cnt < PRIME_C);
  assign frame_start = (state == IDLE) && start;

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    gs_valid   = 1'b0;
    gs_din     = 8'h00;
    case (state)
      IDLE: begin
        if (start) state_nxt = STREAM;
      end
      STREAM: begin
        busy     = 1'b1;
        gs_valid = !src_empty;
        gs_din   = src_data;
        if (gs_valid && gs_ready && (in_cnt == LAST_IN)) state_nxt = FLUSH;
      end
      FLUSH: begin
        // Zero pixels push the last real lines through the window.
        busy     = 1'b1;
        gs_valid = 1'b1;
        if (gs_ready && (fl_cnt == LAST_FL)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (out_cnt == TOTAL) state_nxt = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign src_rd_en   = (state == STREAM) && gs_valid && gs_ready;
  // Discards never wait on the sink; real pixels do.
  assign gs_rd_en_up = busy && (!snk_full || discarding);
  assign out_fire    = gs_valid_out && gs_rd_en_up;
  // Anything beyond the exact frame count is accepted and dropped.
  assign out_write   = out_fire && !discarding && (out_cnt < TOTAL);
  assign snk_wr_en   = out_write;
  assign snk_data    = out_write ? gs_dout : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      in_cnt   <= '0;
      out_cnt  <= '0;
      disc_cnt <= '0;
      fl_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (frame_start) begin
        in_cnt   <= '0;
        out_cnt  <= '0;
        disc_cnt <= '0;
        fl_cnt   <= '0;
      end else begin
        if (src_rd_en)                  in_cnt   <= in_cnt + ONE;
        if ((state == FLUSH) && gs_ready) fl_cnt <= fl_cnt + ONE;
        if (out_fire && discarding)     disc_cnt <= disc_cnt + ONE;
        if (out_write)                  out_cnt  <= out_cnt + ONE;
      end
    end
  end

`ifdef GAUSS_CTRL_STALL_CNT_EN
  logic stall_now;

  // One count per cycle, whether the input side, the output side, or both stall.
  assign stall_now = (((state == STREAM) || (state == FLUSH)) && !(gs_valid && gs_ready)) ||
                     (busy && gs_valid_out && !gs_rd_en_up);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (frame_start) begin
      stall_cycles <= '0;
    end else if (stall_now && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gaussian_frame_ctrl.sv
// Purpose: self-checking bench for gaussian_frame_ctrl with a delay-line wrapper model.
// Latency: n/a (bench).
// Backpressure: source, wrapper and sink stalls are driven from per-vector stimulus settings.
module tb_gaussian_frame_ctrl;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 4;
  localparam int PRIME  = 10;
  localparam int CNT_W  = 8;
  localparam int TOTAL  = IMG_W * IMG_H;
  localparam int BUDGET = 600;
  localparam int NVEC   = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, frame_done;
  logic       src_empty = 1'b1;
  logic       src_rd_en;
  logic [7:0] src_data = 8'h00;
  logic       gs_valid;
  logic [7:0] gs_din;
  logic       gs_ready = 1'b0;
  logic       gs_valid_out = 1'b0;
  logic [7:0] gs_dout = 8'h00;
  logic       gs_rd_en_up;
  logic       snk_full = 1'b0;
  logic       snk_wr_en;
  logic [7:0] snk_data;
`ifdef GAUSS_CTRL_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  gaussian_frame_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PRIME(PRIME), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .src_empty(src_empty), .src_rd_en(src_rd_en), .src_data(src_data),
    .gs_valid(gs_valid), .gs_din(gs_din), .gs_ready(gs_ready),
    .gs_valid_out(gs_valid_out), .gs_dout(gs_dout), .gs_rd_en_up(gs_rd_en_up),
    .snk_full(snk_full), .snk_wr_en(snk_wr_en), .snk_data(snk_data)
`ifdef GAUSS_CTRL_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus settings and expected frame-level results for one frame.
  typedef struct {
    int empty_mode;   // 0 never empty, 1 toggles every 3 cycles, 2 random 30%
    int full_start;
    int full_len;
    int full_rand;    // percent of cycles with random snk_full
    int nr_start;     // forced gs_ready=0 window
    int nr_len;
    bit start_stream;
    bit start_drain;
    bit rand_pix;
    int exp_outs;
    int exp_zeros;
    int exp_done;
    int exp_stall;    // -1: not checked
  } vec_t;

  vec_t  vecs[NVEC];
  string names[NVEC];

  int n_cmp = 0;
  int n_bad = 0;

  byte unsigned src_q[$];
  byte unsigned wq[$];
  byte unsigned dl[PRIME];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Runs one frame against the models. abort_at >= 0 stops once that many
  // source pixels have been consumed (used for the mid-frame reset).
  task automatic run_frame(input vec_t v, input string nm, input int abort_at, output bit aborted);
    byte unsigned exp_q[$];
    byte unsigned got_q[$];
    int cyc, popped, zeros, rd_cnt, dones, errs, post, bad, stall_at_done;
    bit finished, in_drain, empty_now, full_now, nr_now;
    byte unsigned p;
    cyc = 0; popped = 0; zeros = 0; rd_cnt = 0; dones = 0; errs = 0; post = 0;
    stall_at_done = -1; finished = 0; in_drain = 0; aborted = 0;
    src_q.delete();
    wq.delete();
    for (int i = 0; i < TOTAL; i++) begin
      p = v.rand_pix ? 8'($urandom) : 8'(i + 1);
      src_q.push_back(p);
      exp_q.push_back(p);
    end
    // Residue from the next frame keeps the source non-empty during FLUSH.
    for (int i = 0; i < 3; i++) src_q.push_back(8'hEE);
    for (int i = 0; i < PRIME; i++) dl[i] = 8'hA5;

    while (!finished && !aborted && cyc < BUDGET) begin
      @(negedge clk);
      empty_now = (v.empty_mode == 1) ? (((cyc / 3) % 2) == 1) :
                  (v.empty_mode == 2) ? ($urandom_range(99) < 30) : 1'b0;
      full_now  = (cyc >= v.full_start && cyc < v.full_start + v.full_len) ||
                  ($urandom_range(99) < v.full_rand);
      nr_now    = (cyc >= v.nr_start && cyc < v.nr_start + v.nr_len);
      start     = (cyc == 0) || (v.start_stream && cyc == 12) || (v.start_drain && in_drain);
      src_empty = (src_q.size() == 0) || empty_now;
      src_data  = src_empty ? 8'($urandom) : src_q[0];
      snk_full  = full_now;
      gs_ready  = (wq.size() < 3) && !nr_now;
      gs_valid_out = (wq.size() > 0);
      gs_dout   = (wq.size() > 0) ? wq[0] : 8'h00;
      #2;
      if (src_rd_en && src_empty) errs++;
      if (snk_wr_en && snk_full) errs++;
      if (busy && popped < PRIME && !gs_rd_en_up) errs++;
      if (busy && popped >= PRIME && gs_rd_en_up == snk_full) errs++;
      if (!busy && gs_rd_en_up) errs++;
      if (post > 0 && busy) errs++;
      // Wrapper output side: k-th output of the frame is kept only if k >= PRIME.
      if (gs_valid_out && gs_rd_en_up) begin
        if (snk_wr_en != (popped >= PRIME && popped < PRIME + TOTAL)) errs++;
        if (snk_wr_en) begin
          if (snk_data != wq[0]) errs++;
          got_q.push_back(snk_data);
        end
        void'(wq.pop_front());
        popped++;
      end else if (snk_wr_en) begin
        errs++;
      end
      // Wrapper input side: delay line of PRIME samples.
      in_drain = 0;
      if (gs_valid && gs_ready) begin
        if (src_rd_en) begin
          if (gs_din != src_q[0]) errs++;
          void'(src_q.pop_front());
          rd_cnt++;
        end else begin
          if (gs_din != 8'h00) errs++;
          zeros++;
          if (zeros == PRIME) in_drain = 1;
        end
        wq.push_back(dl[PRIME-1]);
        for (int i = PRIME - 1; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = gs_din;
      end else if (src_rd_en) begin
        errs++;
      end
      if (frame_done) begin
        dones++;
`ifdef GAUSS_CTRL_STALL_CNT_EN
        stall_at_done = int'(stall_cycles);
`endif
      end
      if (dones > 0) post++;
      finished = (post >= 5);
      if (abort_at >= 0 && rd_cnt >= abort_at) aborted = 1;
      cyc++;
    end
    start = 1'b0;

    if (!aborted) begin
      check({nm, ".finished"}, int'(finished), 1);
      check({nm, ".out_count"}, got_q.size(), v.exp_outs);
      bad = 0;
      for (int i = 0; i < got_q.size() && i < TOTAL; i++) if (got_q[i] != exp_q[i]) bad++;
      check({nm, ".data_mismatches"}, bad, 0);
      check({nm, ".flush_zeros"}, zeros, v.exp_zeros);
      check({nm, ".src_reads"}, rd_cnt, TOTAL);
      check({nm, ".done_pulses"}, dones, v.exp_done);
      check({nm, ".protocol_errs"}, errs, 0);
`ifdef GAUSS_CTRL_STALL_CNT_EN
      if (v.exp_stall >= 0) check({nm, ".stall_cycles"}, stall_at_done, v.exp_stall);
`endif
    end
  endtask

  initial begin
    bit aborted;
    //                empty fS  fL  fR nrS nrL  sS sD rP  outs   zeros  done stall
    vecs[0] = '{0,    0,  0,  0,  0,  0,  0, 0, 0, TOTAL, PRIME, 1,   0};
    vecs[1] = '{1,    0,  0,  0,  0,  0,  0, 0, 0, TOTAL, PRIME, 1,  -1};
    vecs[2] = '{0,   20, 20,  0,  0,  0,  0, 0, 0, TOTAL, PRIME, 1,  -1};
    vecs[3] = '{0,    0, 14,  0,  0,  0,  0, 0, 0, TOTAL, PRIME, 1,  -1};
    vecs[4] = '{0,    0,  0,  0,  0,  0,  1, 1, 0, TOTAL, PRIME, 1,   0};
    vecs[5] = '{0,    0,  0,  0,  5,  5,  0, 0, 0, TOTAL, PRIME, 1,   5};
    vecs[6] = '{2,    0,  0, 30,  0,  0,  0, 0, 1, TOTAL, PRIME, 1,  -1};
    vecs[7] = '{2,    0,  0, 30,  0,  0,  0, 0, 1, TOTAL, PRIME, 1,  -1};
    vecs[8] = '{2,    0,  0, 30,  0,  0,  0, 0, 1, TOTAL, PRIME, 1,  -1};
    names = '{"basic", "empty_toggle", "full_mid", "full_early", "start_ignored",
              "ready_low", "random0", "random1", "random2"};

    // Reset state with busy-looking inputs applied.
    src_empty = 1'b0; src_data = 8'h5A; gs_ready = 1'b1;
    gs_valid_out = 1'b1; gs_dout = 8'h77; start = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("reset.busy", int'(busy), 0);
    check("reset.frame_done", int'(frame_done), 0);
    check("reset.src_rd_en", int'(src_rd_en), 0);
    check("reset.gs_valid_din", int'({gs_valid, gs_din}), 0);
    check("reset.gs_rd_en_up", int'(gs_rd_en_up), 0);
    check("reset.snk_wr_data", int'({snk_wr_en, snk_data}), 0);
`ifdef GAUSS_CTRL_STALL_CNT_EN
    check("reset.stall_cycles", int'(stall_cycles), 0);
`endif
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NVEC; k++) begin
      run_frame(vecs[k], names[k], -1, aborted);
    end

    // Reset for one cycle once 15 pixels have entered, then a clean frame.
    run_frame(vecs[0], "rst_mid", 15, aborted);
    check("rst_mid.reached_pixel15", int'(aborted), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid.busy", int'(busy), 0);
    check("rst_mid.src_rd_en", int'(src_rd_en), 0);
    check("rst_mid.gs_valid_din", int'({gs_valid, gs_din}), 0);
    check("rst_mid.gs_rd_en_up", int'(gs_rd_en_up), 0);
    check("rst_mid.snk_wr_data", int'({snk_wr_en, snk_data}), 0);
    check("rst_mid.frame_done", int'(frame_done), 0);
`ifdef GAUSS_CTRL_STALL_CNT_EN
    check("rst_mid.stall_cycles", int'(stall_cycles), 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    run_frame(vecs[0], "after_rst", -1, aborted);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
